// File: rtl/ro_rng_ctrl.sv
// Ring-oscillator random number controller.
// Powers the oscillator array only while a request is in flight, lets it
// settle for WARMUP cycles, then captures OUT_W/SIZE samples (one per DIV-cycle
// slot, oldest sample in the MSBs) and hands the word out with valid/ready.
// Optional repetition health test is compiled in with macro RO_RNG_HEALTH_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | oscillators off, waiting for req (ignored once health failed)
// ST_WARMUP | oscillators on, settling before the first sample slot
// ST_SAMPLE | oscillators on, one capture at the end of each DIV-cycle slot
// ST_DONE   | oscillators off, word presented until the consumer takes it
module ro_rng_ctrl #(
   parameter int SIZE      = 8,
   parameter int OUT_W     = 32,
   parameter int WARMUP    = 16,
   parameter int DIV       = 4,
   parameter int REP_LIMIT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   output logic             ro_en,
   input  logic [SIZE-1:0]  ro_bits,
   output logic [OUT_W-1:0] rnd_data,
   output logic             rnd_valid,
   input  logic             rnd_ready,
   output logic             busy,
   output logic             health_fail
);

   localparam int N    = OUT_W / SIZE;
   localparam int CMAX = (WARMUP > DIV) ? WARMUP : DIV;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam int SW   = (N > 1) ? $clog2(N) : 1;

   if (OUT_W % SIZE != 0) begin : g_bad_out_w
      $error("OUT_W must be a multiple of SIZE");
   end
   if (WARMUP < 2 || DIV < 1 || REP_LIMIT < 2) begin : g_bad_timing
      $error("WARMUP >= 2, DIV >= 1 and REP_LIMIT >= 2 required");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_SAMPLE, ST_DONE} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [SW-1:0]     slot_cnt;
   logic [OUT_W-1:0]  word;
   logic [OUT_W-1:0]  word_shifted;
   logic              sample_tick;
   logic              last_slot;
   logic              accept;
   logic              trip;

   assign sample_tick = (state == ST_SAMPLE) && (cnt == '0);
   assign last_slot   = (slot_cnt == SW'(N - 1));
   assign accept      = (state == ST_IDLE) && (state_nxt == ST_WARMUP);

   if (N == 1) begin : g_single
      assign word_shifted = ro_bits;
   end else begin : g_shift
      assign word_shifted = {word[OUT_W-SIZE-1:0], ro_bits};
   end

`ifdef RO_RNG_HEALTH_EN
   localparam int RW = $clog2(REP_LIMIT + 1);
   logic [RW-1:0] rep_cnt, rep_nxt;
   logic          fail_q;

   // Repeat count of the newest capture; the previous capture of this word
   // is always the low SIZE bits of the shift register.
   always_comb begin
      rep_nxt = RW'(1);
      if (slot_cnt != '0 && ro_bits == word[SIZE-1:0])
         rep_nxt = rep_cnt + RW'(1);
   end

   assign trip        = sample_tick && (rep_nxt == RW'(REP_LIMIT));
   assign health_fail = fail_q;

   // Repeat counter and sticky failure flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_cnt <= '0;
         fail_q  <= 1'b0;
      end else begin
         if (sample_tick) rep_cnt <= rep_nxt;
         if (trip)        fail_q  <= 1'b1;
      end
   end
`else
   assign trip        = 1'b0;
   assign health_fail = 1'b0;
`endif

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (req && !health_fail) state_nxt = ST_WARMUP;
         ST_WARMUP: if (cnt == '0) state_nxt = ST_SAMPLE;
         ST_SAMPLE: begin
            if (trip)                         state_nxt = ST_IDLE;
            else if (sample_tick && last_slot) state_nxt = ST_DONE;
         end
         ST_DONE:   if (rnd_ready) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // State register and the registered oscillator enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         ro_en <= 1'b0;
      end else begin
         state <= state_nxt;
         ro_en <= (state_nxt == ST_WARMUP) || (state_nxt == ST_SAMPLE);
      end
   end

   // Down-counter: warm-up length on accept, then reloaded once per slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (accept)
         cnt <= CW'(WARMUP - 1);
      else if (state_nxt == ST_SAMPLE && cnt == '0)
         cnt <= CW'(DIV - 1);
      else if (state_nxt == ST_WARMUP || state_nxt == ST_SAMPLE)
         cnt <= cnt - CW'(1);
      else
         cnt <= '0;
   end

   // Slot index and word assembly; a fresh request wipes the old word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_cnt <= '0;
         word     <= '0;
      end else if (accept) begin
         slot_cnt <= '0;
         word     <= '0;
      end else if (sample_tick) begin
         word <= word_shifted;
         if (!last_slot) slot_cnt <= slot_cnt + SW'(1);
      end
   end

   assign rnd_data  = word;
   assign rnd_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);

endmodule

// File: doc/ro_rng_ctrl.md
RO_RNG_CTRL -- requirements
Module: ro_rng_ctrl

Interface
REQ-001 The block SHALL have parameter SIZE, default 8: width of one ring-oscillator sample word (ro_bits).
REQ-002 The block SHALL have parameter OUT_W, default 32: width of the delivered random word; SHALL be a multiple of SIZE; N = OUT_W/SIZE samples per word.
REQ-003 The block SHALL have parameter WARMUP, default 16, minimum 2: ro_en-high cycles before the first sample slot.
REQ-004 The block SHALL have parameter DIV, default 4, minimum 1: cycles per sample slot.
REQ-005 The block SHALL have parameter REP_LIMIT, default 3, minimum 2: identical-sample count that trips the health test.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port req, input, 1 bit: request for one random word.
REQ-009 The block SHALL have port ro_en, output, 1 bit: enable to the ring-oscillator array, registered.
REQ-010 The block SHALL have port ro_bits, input, SIZE bits: registered XOR bits from the array.
REQ-011 The block SHALL have port rnd_data, output, OUT_W bits: assembled random word.
REQ-012 The block SHALL have port rnd_valid, output, 1 bit: rnd_data valid.
REQ-013 The block SHALL have port rnd_ready, input, 1 bit: consumer accepts rnd_data.
REQ-014 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 The block SHALL have port health_fail, output, 1 bit: sticky health-test failure flag.

Function
REQ-016 The FSM SHALL have states IDLE, WARMUP, SAMPLE and DONE.
REQ-017 In IDLE with req=1 and health_fail=0, the FSM SHALL go to WARMUP on the next edge; req SHALL be ignored in all other states.
REQ-018 ro_en SHALL be 1 exactly in WARMUP and SAMPLE, and 0 in IDLE and DONE; the oscillators SHALL never run outside a request.
REQ-019 WARMUP SHALL last exactly WARMUP cycles and then go to SAMPLE.
REQ-020 SAMPLE SHALL consist of N slots of DIV cycles each; on the last cycle of each slot, ro_bits SHALL be captured as: word <= {word[OUT_W-SIZE-1:0], ro_bits}.
REQ-021 After the Nth capture the FSM SHALL go to DONE; the first captured sample SHALL end up in rnd_data[OUT_W-1:OUT_W-SIZE].
REQ-022 Latency SHALL be: req sampled at edge e0 -> rnd_valid high after edge e0+WARMUP+N*DIV (defaults: 32 edges).
REQ-023 rnd_valid SHALL equal (state==DONE); rnd_data SHALL be held stable while rnd_valid=1.
REQ-024 On rnd_valid & rnd_ready at an edge, the FSM SHALL go to IDLE and rnd_valid SHALL drop the next cycle; a new req SHALL be accepted from IDLE no earlier than the following edge.
REQ-025 rnd_ready=0 SHALL hold DONE indefinitely, with ro_en=0.
REQ-026 rnd_data SHALL be cleared to 0 when a request is accepted, so no prior word leaks into a new one.

Reset
REQ-027 While rst=1, asynchronously: state=IDLE, ro_en=0, rnd_valid=0, busy=0, rnd_data=0, health_fail=0, all counters=0.
REQ-028 rst asserted mid-WARMUP/SAMPLE/DONE SHALL drop ro_en immediately, and the partial word SHALL be discarded.

Configuration
REQ-029 With macro RO_RNG_HEALTH_EN defined, each capture SHALL be compared to the previous capture of the same word; equal SHALL increment a repeat count (first capture = 1), unequal SHALL reset it to 1.
REQ-030 With RO_RNG_HEALTH_EN defined, when the repeat count reaches REP_LIMIT, health_fail SHALL set on that edge (sticky until rst), the FSM SHALL go to IDLE, no rnd_valid SHALL be issued, and further req SHALL be ignored.
REQ-031 Without RO_RNG_HEALTH_EN, no comparison logic SHALL exist, health_fail SHALL be tied 0, and every word SHALL be delivered.

Verification
REQ-032 Defaults; pulse req 1 cycle; ro_bits = 0x11,0x22,0x33,0x44 in successive slots -> rnd_valid after 32 edges, rnd_data=0x11223344, ro_en high exactly 32 cycles.
REQ-033 Hold rnd_ready=0 for 10 cycles in DONE -> rnd_data stable, ro_en=0, busy=1; raise rnd_ready -> IDLE next edge, rnd_valid=0.
REQ-034 req held high continuously -> words spaced by 32+handshake+1 cycles; req pulses during WARMUP/SAMPLE have no effect.
REQ-035 Assert rst at slot 2 of SAMPLE -> ro_en and busy 0 without a clock edge; next req produces a clean word with no prior bits.
REQ-036 RO_RNG_HEALTH_EN defined, ro_bits stuck at 0xA5 -> health_fail=1 at the 3rd capture, ro_en=0, no rnd_valid, later req ignored until rst.
REQ-037 RO_RNG_HEALTH_EN undefined, same stuck stimulus -> rnd_data=0xA5A5A5A5 delivered, health_fail=0.
